// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store front end.
//   - register-write (load mode) codes consumed by the WB extension logic
//   - store-type codes as presented by the EX/MEM register
//   - FSM state encoding
//   - misalignment helper
package mem_access_unit_pkg;

    // Register-write / load-mode codes
    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    // Store-type codes
    localparam logic [1:0] STORE_NONE = 2'b00;
    localparam logic [1:0] STORE_SB   = 2'b01;
    localparam logic [1:0] STORE_SH   = 2'b10;
    localparam logic [1:0] STORE_SW   = 2'b11;

    // Wait counter width; covers MAX_WAIT up to 1023
    localparam int WAIT_W = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
    // The store type decides the access size whenever the op is a store.
    function automatic logic op_misaligned(input logic       is_store,
                                           input logic [1:0] store_type,
                                           input logic [2:0] load_type,
                                           input logic [1:0] byte_off);
        logic is_half;
        logic is_word;
        is_half = is_store ? (store_type == STORE_SH) : (load_type == LH || load_type == LHU);
        is_word = is_store ? (store_type == STORE_SW) : (load_type == LW);
        return (is_half && byte_off[0]) || (is_word && byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_store_lane_align.sv
// store_lane_align: combinational byte-lane steering for stores.
//   i_store_type : STORE_NONE/SB/SH/SW
//   i_byte_off   : ex_addr[1:0]
//   i_wdata      : rs2 store data
//   o_we         : per-byte write enables (0 for loads / no store)
//   o_wdata      : store data replicated across lanes
module store_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  i_store_type,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_we    = 4'b0000;
        o_wdata = i_wdata;
        case (i_store_type)
            STORE_SB: begin
                o_we    = 4'b0001 << i_byte_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            STORE_SH: begin
                o_we    = 4'b0011 << i_byte_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            STORE_SW: begin
                o_we    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: begin
                o_we    = 4'b0000;
                o_wdata = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store front end.
// Takes one op from EX/MEM, runs a req/ready access to a word-addressed data
// memory, stalls upstream while the access is outstanding and hands the raw
// word plus byte select / load mode to the WB extension logic.
// Ports:
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_ex_*                        : op from EX/MEM (valid, addr, wdata, store/load type, rd)
//   o_stall_out                   : hold upstream pipeline
//   o_mem_req/addr/we/wdata       : memory request, held stable while BUSY
//   i_mem_ready, i_mem_rdata      : memory completion and read word
//   o_wb_valid/data/byte_sel/regwrite/rd : one-cycle completion to WB
//   o_misalign_exc, o_bus_err     : one-cycle exception pulses
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_addr,
    input  logic [31:0] i_ex_wdata,
    input  logic [1:0]  i_ex_store_type,
    input  logic [2:0]  i_ex_load_type,
    input  logic [4:0]  i_ex_rd,
    output logic        o_stall_out,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [1:0]  o_wb_byte_sel,
    output logic [2:0]  o_wb_regwrite,
    output logic [4:0]  o_wb_rd,
    output logic        o_misalign_exc,
    output logic        o_bus_err
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t              r_state, w_next_state;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_is_store;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    logic [3:0]          r_mem_we;
    logic [31:0]         r_mem_wdata;
    logic                r_wb_valid;
    logic [31:0]         r_wb_data;
    logic [1:0]          r_wb_byte_sel;
    logic [2:0]          r_wb_regwrite;
    logic [4:0]          r_wb_rd;
    logic                r_misalign;
    logic                r_bus_err;

    logic                w_is_store;
    logic                w_is_load;
    logic                w_op;
    logic                w_mis;
    logic                w_accept;
    logic                w_misalign;
    logic                w_timeout;
    logic [3:0]          w_we;
    logic [31:0]         w_wdata;

    // Store type wins over load type when both are set
    assign w_is_store = (i_ex_store_type != STORE_NONE);
    assign w_is_load  = !w_is_store && (i_ex_load_type != NOREGWRITE);
    assign w_op       = i_ex_valid && (w_is_store || w_is_load);
    assign w_mis      = op_misaligned(w_is_store, i_ex_store_type, i_ex_load_type, i_ex_addr[1:0]);

    // Ops arriving while BUSY are the same op held by the stall, so only IDLE looks at them
    assign w_accept   = (r_state == ST_IDLE) && w_op && !w_mis;
    assign w_misalign = (r_state == ST_IDLE) && w_op &&  w_mis;

    // Last allowed BUSY cycle without ready; a ready in this cycle still completes
    assign w_timeout  = (r_state == ST_BUSY) && !i_mem_ready && (r_wait == WAIT_LAST);

    store_lane_align u_align (
        .i_store_type (i_ex_store_type),
        .i_byte_off   (i_ex_addr[1:0]),
        .i_wdata      (i_ex_wdata),
        .o_we         (w_we),
        .o_wdata      (w_wdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        o_stall_out  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_BUSY;
                    o_stall_out  = 1'b1;
                end
            end
            ST_BUSY: begin
                o_stall_out = !i_mem_ready;
                if (i_mem_ready || w_timeout) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Nothing can be accepted while reset is held, so never stall upstream then
        if (!i_rst_n) o_stall_out = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait        <= '0;
            r_is_store    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= '0;
            r_mem_wdata   <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_byte_sel <= '0;
            r_wb_regwrite <= NOREGWRITE;
            r_wb_rd       <= '0;
            r_misalign    <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;

            if (w_misalign) r_misalign <= 1'b1;

            if (w_accept) begin
                r_mem_req     <= 1'b1;
                r_mem_addr    <= {i_ex_addr[31:2], 2'b00};
                r_mem_we      <= w_we;
                r_mem_wdata   <= w_wdata;
                r_wait        <= '0;
                r_is_store    <= w_is_store;
                r_wb_byte_sel <= i_ex_addr[1:0];
                r_wb_regwrite <= w_is_store ? NOREGWRITE : i_ex_load_type;
                r_wb_rd       <= i_ex_rd;
            end

            if (r_state == ST_BUSY) begin
                if (i_mem_ready) begin
                    r_mem_req  <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= r_is_store ? 32'h0 : i_mem_rdata;
                end else if (w_timeout) begin
                    r_mem_req <= 1'b0;
                    r_bus_err <= 1'b1;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
            end
        end
    end

    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_we       = r_mem_we;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_data      = r_wb_data;
    assign o_wb_byte_sel  = r_wb_byte_sel;
    assign o_wb_regwrite  = r_wb_regwrite;
    assign o_wb_rd        = r_wb_rd;
    assign o_misalign_exc = r_misalign;
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: each driven op pushes its expected
// completion event (kind, cycle, wb fields); a negedge monitor pops and
// compares whenever a completion/exception pulse appears.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int MAXW = 4;
    localparam int K_WB = 0, K_MIS = 1, K_BERR = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_st;
    logic [2:0]  ex_lt;
    logic [4:0]  ex_rd;
    logic        stall_out, mem_req, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic        wb_valid, misalign_exc, bus_err;
    logic [31:0] wb_data;
    logic [1:0]  wb_byte_sel;
    logic [2:0]  wb_regwrite;
    logic [4:0]  wb_rd;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
        logic [1:0]  bsel;
        logic [2:0]  rw;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;

    mem_access_unit #(.MAX_WAIT(MAXW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ex_valid(ex_valid), .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata),
        .i_ex_store_type(ex_st), .i_ex_load_type(ex_lt), .i_ex_rd(ex_rd),
        .o_stall_out(stall_out), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_wb_valid(wb_valid), .o_wb_data(wb_data), .o_wb_byte_sel(wb_byte_sel),
        .o_wb_regwrite(wb_regwrite), .o_wb_rd(wb_rd),
        .o_misalign_exc(misalign_exc), .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent model of lane steering
    function automatic logic [3:0] m_we(input logic [1:0] st, input logic [1:0] off);
        case (st)
            STORE_SB: return (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                             (off == 2'd2) ? 4'b0100 : 4'b1000;
            STORE_SH: return (off == 2'd0) ? 4'b0011 : 4'b1100;
            STORE_SW: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] st, input logic [31:0] d);
        case (st)
            STORE_SB: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            STORE_SH: return {d[15:0], d[15:0]};
            default:  return d;
        endcase
    endfunction

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (wb_valid || misalign_exc || bus_err)) begin
            chk("pulse_excl", 32'($countones({wb_valid, misalign_exc, bus_err})), 32'd1);
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, wb_valid, misalign_exc, bus_err}, 32'd0);
            end else begin
                exp_t e;
                int   k;
                e = sb_q.pop_front();
                k = wb_valid ? K_WB : misalign_exc ? K_MIS : K_BERR;
                chk("ev_kind", 32'(k), 32'(e.kind));
                chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind == K_WB && wb_valid) begin
                    chk("wb_data", wb_data, e.data);
                    chk("wb_byte_sel", 32'(wb_byte_sel), 32'(e.bsel));
                    chk("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] st, input logic [2:0] lt,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        ex_valid = v; ex_st = st; ex_lt = lt; ex_addr = a; ex_wdata = d; ex_rd = rd;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(1'b0, STORE_NONE, NOREGWRITE, 32'h0, 32'h0, 5'd0);
            @(negedge clk);
            chk("idle_stall", 32'(stall_out), 32'd0);
            chk("idle_req", 32'(mem_req), 32'd0);
        end
    endtask

    // Aligned op: ready arrives in BUSY cycle wait_n+1, or never if wait_n >= MAXW
    task automatic do_op(input logic [1:0] st, input logic [2:0] lt, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input int wait_n,
                         input logic [31:0] rdata);
        exp_t e;
        int   acc, busy_n, stalls;
        logic tmo, rdy, is_st;
        @(posedge clk); #1;
        drive(1'b1, st, lt, a, d, rd);
        acc    = cyc;
        tmo    = (wait_n >= MAXW);
        busy_n = tmo ? MAXW : wait_n + 1;
        is_st  = (st != STORE_NONE);
        e.kind = tmo ? K_BERR : K_WB;
        e.cyc  = acc + busy_n + 1;
        e.data = is_st ? 32'h0 : rdata;
        e.bsel = a[1:0];
        e.rw   = is_st ? NOREGWRITE : lt;
        e.rd   = rd;
        sb_q.push_back(e);
        @(negedge clk);
        chk("acc_stall", 32'(stall_out), 32'd1);
        chk("acc_req", 32'(mem_req), 32'd0);
        stalls = 1;
        for (int k = 1; k <= busy_n; k++) begin
            @(posedge clk); #1;
            rdy       = (k > wait_n);
            mem_ready = rdy;
            mem_rdata = rdy ? rdata : ~rdata;
            @(negedge clk);
            chk("busy_req", 32'(mem_req), 32'd1);
            chk("busy_addr", mem_addr, {a[31:2], 2'b00});
            chk("busy_we", 32'(mem_we), 32'(m_we(st, a[1:0])));
            if (is_st) chk("busy_wdata", mem_wdata, m_wd(st, d));
            chk("busy_stall", 32'(stall_out), 32'(!rdy));
            if (stall_out) stalls++;
        end
        chk("stall_cycles", 32'(stalls), 32'(tmo ? MAXW + 1 : wait_n + 1));
    endtask

    task automatic mis_op(input logic [1:0] st, input logic [2:0] lt, input logic [31:0] a);
        exp_t e;
        @(posedge clk); #1;
        drive(1'b1, st, lt, a, 32'h5555_AAAA, 5'd9);
        e.kind = K_MIS; e.cyc = cyc + 1; e.data = 0; e.bsel = 0; e.rw = 0; e.rd = 0;
        sb_q.push_back(e);
        @(negedge clk);
        chk("mis_stall", 32'(stall_out), 32'd0);
        chk("mis_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, STORE_NONE, NOREGWRITE, 32'h0, 32'h0, 5'd0);
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_pulses", {29'd0, wb_valid, misalign_exc, bus_err}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(2);

        do_op(STORE_SB, NOREGWRITE, 32'h0000_1003, 32'h0000_00A5, 5'd0, 2, 32'hFFFF_FFFF);
        idle(2);
        do_op(STORE_NONE, LH, 32'h0000_2002, 32'h0, 5'd7, 0, 32'h8001_1234);
        idle(1);
        mis_op(STORE_NONE, LW, 32'h0000_3001);
        idle(1);
        mis_op(STORE_SH, LW, 32'h0000_0021);   // store wins: SH at odd address
        mis_op(STORE_NONE, LHU, 32'h0000_0023);
        idle(1);
        do_op(STORE_SH, NOREGWRITE, 32'h0000_2002, 32'h1234_BEEF, 5'd3, 1, 32'h0F0F_0F0F);
        do_op(STORE_SB, LW, 32'h0000_0003, 32'h0000_003C, 5'd4, 0, 32'h1111_2222);
        idle(1);

        // ignored: valid with neither store nor load
        @(posedge clk); #1;
        drive(1'b1, STORE_NONE, NOREGWRITE, 32'h0000_0040, 32'h0, 5'd1);
        @(negedge clk);
        chk("ign_stall", 32'(stall_out), 32'd0);
        idle(1);

        do_op(STORE_NONE, LW, 32'h0000_0040, 32'h0, 5'd5, 100, 32'hCAFE_0000);   // timeout
        idle(2);
        do_op(STORE_NONE, LB, 32'h0000_0045, 32'h0, 5'd6, MAXW - 1, 32'hA1B2_C3D4); // ready at limit
        idle(1);

        // back-to-back
        do_op(STORE_SW, NOREGWRITE, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1, 32'h7777_7777);
        do_op(STORE_NONE, LBU, 32'h0000_0011, 32'h0, 5'd12, 0, 32'h1122_3344);
        idle(2);

        // reset during BUSY
        @(posedge clk); #1;
        drive(1'b1, STORE_NONE, LW, 32'h0000_0200, 32'h0, 5'd8);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, STORE_NONE, NOREGWRITE, 32'h0, 32'h0, 5'd0);
        rst_n = 1'b1;
        idle(3);
        do_op(STORE_NONE, LW, 32'h0000_0100, 32'h0, 5'd31, 0, 32'h0BAD_F00D);
        idle(3);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store front end of the RV32 pipeline.
- Accepts one memory op per transaction from the EX/MEM register and drives a variable-latency word-addressed data memory with a req/ready handshake.
- Stalls the pipeline while the access is outstanding.
- Produces the registered raw word, byte-select and load mode that the WB-stage data-extension logic consumes.

Parameters:
- MAX_WAIT, 255: cycles in BUSY without mem_ready before the access is aborted with bus_err. Range 1..1023.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  memory op present in MEM stage.
- ex_addr  in  32  byte address (ALU result).
- ex_wdata  in  32  store data (rs2).
- ex_store_type  in  2  00 none, 01 SB, 10 SH, 11 SW.
- ex_load_type  in  3  register-write mode: NOREGWRITE/LB/LH/LW/LBU/LHU codes.
- ex_rd  in  5  destination register.
- stall_out  out  1  hold upstream pipeline.
- mem_req  out  1  memory request.
- mem_addr  out  32  word-aligned address {ex_addr[31:2],2'b00}.
- mem_we  out  4  byte write enables; 0 means read.
- mem_wdata  out  32  lane-aligned store data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  32  read word, valid when mem_ready.
- wb_valid  out  1  one-cycle completion pulse.
- wb_data  out  32  raw loaded word.
- wb_byte_sel  out  2  ex_addr[1:0] of the completed op.
- wb_regwrite  out  3  load mode, or NOREGWRITE for stores.
- wb_rd  out  5  destination register.
- misalign_exc  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs go to 0 and the wait counter clears.
  - Reset asserted mid-transaction drops mem_req immediately; no wb_valid follows.
- Op classification:
  - An op is a store if ex_store_type!=00; this takes precedence, and wb_regwrite is forced to NOREGWRITE.
  - Otherwise it is a load if ex_load_type!=NOREGWRITE.
  - ex_valid with neither is ignored.
- Misalignment:
  - Halfword op (SH/LH/LHU) with addr[0]=1, or word op (SW/LW) with addr[1:0]!=0, is misaligned.
  - A misaligned op gets misalign_exc=1 on the next cycle, no mem_req, no wb_valid and no stall.
- FSM states: IDLE, BUSY.
- IDLE:
  - An aligned valid op is accepted; stall_out=1 combinationally.
  - At the clock edge, mem_addr, mem_we, mem_wdata and the wb metadata are latched, mem_req goes to 1 and the state moves to BUSY.
- BUSY:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ready.
  - stall_out = !mem_ready.
  - On mem_ready: state returns to IDLE and mem_req drops at the edge. Next cycle wb_valid=1 with wb_data=mem_rdata captured at that edge; for stores, wb_data=0.
  - The upstream stage advances on the mem_ready edge, so back-to-back ops have 1 idle cycle between requests.
- Latency: with mem_ready in the first BUSY cycle, wb_valid rises 2 cycles after the accept cycle.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<addr[1:0].
  - SW: 4'b1111.
  - Loads: 4'b0000.
- Store data replication:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
- Wait counter:
  - Clears on accept and increments each BUSY cycle without mem_ready.
  - If it reaches MAX_WAIT, the state returns to IDLE, mem_req drops, bus_err pulses 1 cycle, wb_valid stays 0 and stall_out releases.
  - mem_ready in the same cycle as the limit counts as a success.
- Ignored inputs: ex_valid while in BUSY is ignored, because upstream is held stable by the stall.
- Output pulses: wb_valid, misalign_exc and bus_err are each high for exactly one cycle and are mutually exclusive.

Decomposition:
- Shared parameters include file holds:
  - the existing NOREGWRITE/LB/LH/LW/LBU/LHU register-write codes;
  - new store-type codes (STORE_NONE/SB/SH/SW);
  - FSM state encodings.
- One natural sub-module: store_lane_align. It is combinational and maps store type and addr[1:0] to mem_we and mem_wdata.

Test Plan:
- SB addr=0x1003, wdata=0x000000A5, mem_ready after 2 BUSY cycles -> mem_addr=0x1000, mem_we=4'b1000, mem_wdata=0xA5A5A5A5, stall_out high for 3 cycles, wb_valid with wb_regwrite=NOREGWRITE.
- LH addr=0x2002, mem_rdata=0x8001_1234, mem_ready in first BUSY cycle -> mem_we=0, wb_valid 2 cycles after accept, wb_data=0x80011234, wb_byte_sel=2'b10, wb_regwrite=LH.
- LW addr=0x3001 -> misalign_exc pulse next cycle, mem_req never asserted, stall_out 0.
- Load with mem_ready held low and MAX_WAIT=4 -> mem_req high 4 cycles, then bus_err pulse, no wb_valid, stall released.
- Back-to-back SW 0x10 then LBU 0x11 -> two separate requests, LBU wb_byte_sel=2'b01, first request's data unchanged while BUSY.
- rst_n low during BUSY -> mem_req and stall_out go 0 immediately; after release, state is IDLE with no spurious pulses.
